// File: rtl/usr_pkg.sv
// Shared types and helpers for the universal shift register.
package usr_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } usr_mode_e;

  // Counter width able to hold 0..width.
  function automatic int usr_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/usr_frame_counter.sv
// Shift counter: counts shifts modulo WIDTH and pulses done after each full frame.
module usr_frame_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             zero,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // zero (clear or load) overrides a shift in the same cycle, so no pulse is produced.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (zero) begin
      cnt_d = '0;
    end else if (inc) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = done_q;

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load,
// with synchronous clear and a frame counter that flags every WIDTH shifts.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = usr_cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic             serial_in_msb,
  input  logic             serial_in_lsb,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out_r,
  output logic             serial_out_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             cnt_inc, cnt_zero;
  usr_mode_e        mode_e;

  assign mode_e = usr_mode_e'(mode);

  // Priority: clr over the enable, and the enable over the mode.
  always_comb begin
    q_d      = q_q;
    cnt_inc  = 1'b0;
    cnt_zero = 1'b0;
    if (clr) begin
      q_d      = '0;
      cnt_zero = 1'b1;
    end else if (en) begin
      unique case (mode_e)
        MODE_HOLD: q_d = q_q;
        MODE_SHR: begin
          q_d     = {serial_in_msb, q_q[WIDTH-1:1]};
          cnt_inc = 1'b1;
        end
        MODE_SHL: begin
          q_d     = {q_q[WIDTH-2:0], serial_in_lsb};
          cnt_inc = 1'b1;
        end
        MODE_LOAD: begin
          q_d      = par_in;
          cnt_zero = 1'b1;
        end
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  usr_frame_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_frame_counter (
    .clk (clk),
    .rst (rst),
    .inc (cnt_inc),
    .zero(cnt_zero),
    .cnt (shift_cnt),
    .done(frame_done)
  );

  assign q            = q_q;
  assign serial_out_r = q_q[0];
  assign serial_out_l = q_q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg: WIDTH=4 and WIDTH=8 instances,
// directed vectors with hand-computed expectations checked by a monitor.
module tb_universal_shift_reg;
  import usr_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       en4, clr4, msb4, lsb4;
  logic [1:0] mode4;
  logic [3:0] par4, q4;
  logic       sor4, sol4, fd4;
  logic [2:0] cnt4;

  logic       en8, clr8, msb8, lsb8;
  logic [1:0] mode8;
  logic [7:0] par8, q8;
  logic       sor8, sol8, fd8;
  logic [3:0] cnt8;

  universal_shift_reg #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .clr(clr4), .mode(mode4),
    .serial_in_msb(msb4), .serial_in_lsb(lsb4), .par_in(par4),
    .q(q4), .serial_out_r(sor4), .serial_out_l(sol4),
    .shift_cnt(cnt4), .frame_done(fd4)
  );

  universal_shift_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .clr(clr8), .mode(mode8),
    .serial_in_msb(msb8), .serial_in_lsb(lsb8), .par_in(par8),
    .q(q8), .serial_out_r(sor8), .serial_out_l(sol8),
    .shift_cnt(cnt8), .frame_done(fd8)
  );

  typedef struct {
    string      name;
    bit         w8;
    logic [7:0] q;
    logic [3:0] cnt;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every cycle with a pending expectation, compare the state after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.w8) begin
          check({e.name, ".q"},    q8,          e.q);
          check({e.name, ".cnt"},  {4'b0, cnt8}, {4'b0, e.cnt});
          check({e.name, ".done"}, {7'b0, fd8},  {7'b0, e.done});
          check({e.name, ".sor"},  {7'b0, sor8}, {7'b0, e.q[0]});
          check({e.name, ".sol"},  {7'b0, sol8}, {7'b0, e.q[7]});
        end else begin
          check({e.name, ".q"},    {4'b0, q4},   {4'b0, e.q[3:0]});
          check({e.name, ".cnt"},  {5'b0, cnt4}, {5'b0, e.cnt[2:0]});
          check({e.name, ".done"}, {7'b0, fd4},  {7'b0, e.done});
          check({e.name, ".sor"},  {7'b0, sor4}, {7'b0, e.q[0]});
          check({e.name, ".sol"},  {7'b0, sol4}, {7'b0, e.q[3]});
        end
      end
    end
  end

  // Drive one cycle on the selected instance and queue the state expected after the edge.
  task automatic cyc(input bit w8, input logic e, input logic c, input logic [1:0] m,
                     input logic msb, input logic lsb, input logic [7:0] par,
                     input logic [7:0] eq, input logic [3:0] ec, input logic ed,
                     input string nm);
    exp_t x;
    @(negedge clk);
    if (w8) begin
      en8 = e; clr8 = c; mode8 = m; msb8 = msb; lsb8 = lsb; par8 = par;
      en4 = 1'b0; clr4 = 1'b0;
    end else begin
      en4 = e; clr4 = c; mode4 = m; msb4 = msb; lsb4 = lsb; par4 = par[3:0];
      en8 = 1'b0; clr8 = 1'b0;
    end
    x.name = nm; x.w8 = w8; x.q = eq; x.cnt = ec; x.done = ed;
    sb.push_back(x);
  endtask

  task automatic drain();
    @(negedge clk);
    en4 = 1'b0; en8 = 1'b0; clr4 = 1'b0; clr8 = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    check("drain", 8'(sb.size()), 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en4 = 0; clr4 = 0; mode4 = MODE_HOLD; msb4 = 0; lsb4 = 0; par4 = '0;
    en8 = 0; clr8 = 0; mode8 = MODE_HOLD; msb8 = 0; lsb8 = 0; par8 = '0;
    #1;
    check("init.q4",   {4'b0, q4},   8'h00);
    check("init.cnt4", {5'b0, cnt4}, 8'h00);
    check("init.fd4",  {7'b0, fd4},  8'h00);
    check("init.q8",   q8,           8'h00);
    check("init.cnt8", {4'b0, cnt8}, 8'h00);
    check("init.fd8",  {7'b0, fd8},  8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Legacy 4-bit right shift
    cyc(0, 1, 0, MODE_SHR,  1, 0, 8'hFF, 8'h8, 4'd1, 0, "leg1");
    cyc(0, 1, 0, MODE_SHR,  0, 1, 8'hFF, 8'h4, 4'd2, 0, "leg2");
    cyc(0, 1, 0, MODE_SHR,  1, 0, 8'hFF, 8'hA, 4'd3, 0, "leg3");
    cyc(0, 1, 0, MODE_SHR,  1, 0, 8'hFF, 8'hD, 4'd0, 1, "leg4");
    cyc(0, 1, 0, MODE_HOLD, 1, 1, 8'hFF, 8'hD, 4'd0, 0, "leg_hold");
    drain();

    // Asynchronous reset mid-frame
    cyc(0, 1, 0, MODE_LOAD, 1, 1, 8'h05, 8'h5, 4'd0, 0, "rst_load");
    cyc(0, 1, 0, MODE_SHL,  0, 1, 8'hFF, 8'hB, 4'd1, 0, "rst_shl");
    drain();
    rst = 1'b1;
    #1;
    check("async_rst.q4",   {4'b0, q4},   8'h00);
    check("async_rst.cnt4", {5'b0, cnt4}, 8'h00);
    check("async_rst.fd4",  {7'b0, fd4},  8'h00);
    check("async_rst.sor4", {7'b0, sor4}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 1, 0, MODE_SHR, 0, 1, 8'hFF, 8'h0, 4'd1, 0, "post_rst1");
    cyc(0, 1, 0, MODE_SHR, 0, 1, 8'hFF, 8'h0, 4'd2, 0, "post_rst2");
    cyc(0, 1, 0, MODE_SHR, 0, 1, 8'hFF, 8'h0, 4'd3, 0, "post_rst3");
    drain();

    // 8-bit left shift of A5 and frame wrap
    cyc(1, 1, 0, MODE_LOAD, 1, 1, 8'hA5, 8'hA5, 4'd0, 0, "shl_load");
    cyc(1, 1, 0, MODE_SHL,  1, 0, 8'hFF, 8'h4A, 4'd1, 0, "shl1");
    cyc(1, 1, 0, MODE_SHL,  1, 0, 8'hFF, 8'h94, 4'd2, 0, "shl2");
    cyc(1, 1, 0, MODE_SHL,  1, 0, 8'hFF, 8'h28, 4'd3, 0, "shl3");
    cyc(1, 1, 0, MODE_SHL,  1, 0, 8'hFF, 8'h50, 4'd4, 0, "shl4");
    cyc(1, 1, 0, MODE_SHL,  1, 0, 8'hFF, 8'hA0, 4'd5, 0, "shl5");
    cyc(1, 1, 0, MODE_SHL,  1, 0, 8'hFF, 8'h40, 4'd6, 0, "shl6");
    cyc(1, 1, 0, MODE_SHL,  1, 0, 8'hFF, 8'h80, 4'd7, 0, "shl7");
    cyc(1, 1, 0, MODE_SHL,  1, 0, 8'hFF, 8'h00, 4'd0, 1, "shl8");
    cyc(1, 1, 0, MODE_HOLD, 1, 1, 8'hFF, 8'h00, 4'd0, 0, "shl_hold");
    drain();

    // Mixed direction on WIDTH=4
    cyc(0, 1, 0, MODE_LOAD, 1, 1, 8'h06, 8'h6, 4'd0, 0, "mix_load");
    cyc(0, 1, 0, MODE_SHR,  0, 1, 8'hFF, 8'h3, 4'd1, 0, "mix_shr0");
    cyc(0, 1, 0, MODE_SHL,  0, 1, 8'hFF, 8'h7, 4'd2, 0, "mix_shl1");
    cyc(0, 1, 0, MODE_HOLD, 1, 1, 8'hFF, 8'h7, 4'd2, 0, "mix_hold");
    cyc(0, 1, 0, MODE_SHR,  1, 0, 8'hFF, 8'hB, 4'd3, 0, "mix_shr1");
    cyc(0, 1, 0, MODE_SHR,  0, 1, 8'hFF, 8'h5, 4'd0, 1, "mix_wrap");
    cyc(0, 1, 0, MODE_HOLD, 1, 1, 8'hFF, 8'h5, 4'd0, 0, "mix_after");
    drain();

    // Clear beats enable, then back-to-back frames on WIDTH=4
    cyc(0, 1, 1, MODE_SHL, 0, 1, 8'hFF, 8'h0, 4'd0, 0, "clr_en");
    cyc(0, 1, 0, MODE_SHL, 0, 1, 8'hFF, 8'h1, 4'd1, 0, "b2b1");
    cyc(0, 1, 0, MODE_SHL, 0, 1, 8'hFF, 8'h3, 4'd2, 0, "b2b2");
    cyc(0, 1, 0, MODE_SHL, 0, 1, 8'hFF, 8'h7, 4'd3, 0, "b2b3");
    cyc(0, 1, 0, MODE_SHL, 0, 1, 8'hFF, 8'hF, 4'd0, 1, "b2b4");
    cyc(0, 1, 0, MODE_SHL, 0, 1, 8'hFF, 8'hF, 4'd1, 0, "b2b5");
    cyc(0, 1, 0, MODE_SHL, 0, 1, 8'hFF, 8'hF, 4'd2, 0, "b2b6");
    cyc(0, 1, 0, MODE_SHL, 0, 1, 8'hFF, 8'hF, 4'd3, 0, "b2b7");
    cyc(0, 1, 0, MODE_SHL, 0, 1, 8'hFF, 8'hF, 4'd0, 1, "b2b8");
    drain();

    // Priority: LOAD at the frame-completing cycle, then clear with en=0
    cyc(1, 1, 0, MODE_LOAD, 0, 0, 8'h00, 8'h00, 4'd0, 0, "pri_load0");
    cyc(1, 1, 0, MODE_SHR,  1, 0, 8'hFF, 8'h80, 4'd1, 0, "pri1");
    cyc(1, 1, 0, MODE_SHR,  1, 0, 8'hFF, 8'hC0, 4'd2, 0, "pri2");
    cyc(1, 1, 0, MODE_SHR,  1, 0, 8'hFF, 8'hE0, 4'd3, 0, "pri3");
    cyc(1, 1, 0, MODE_SHR,  1, 0, 8'hFF, 8'hF0, 4'd4, 0, "pri4");
    cyc(1, 1, 0, MODE_SHR,  1, 0, 8'hFF, 8'hF8, 4'd5, 0, "pri5");
    cyc(1, 1, 0, MODE_SHR,  1, 0, 8'hFF, 8'hFC, 4'd6, 0, "pri6");
    cyc(1, 1, 0, MODE_SHR,  1, 0, 8'hFF, 8'hFE, 4'd7, 0, "pri7");
    cyc(1, 1, 0, MODE_LOAD, 1, 0, 8'h3C, 8'h3C, 4'd0, 0, "pri_load");
    cyc(1, 0, 1, MODE_SHR,  1, 0, 8'hFF, 8'h00, 4'd0, 0, "pri_clr_noen");
    drain();

    // Enable gating
    cyc(1, 1, 0, MODE_LOAD, 1, 0, 8'h5A, 8'h5A, 4'd0, 0, "gate_load");
    cyc(1, 1, 0, MODE_SHR,  1, 0, 8'hFF, 8'hAD, 4'd1, 0, "gate_shr");
    for (int i = 0; i < 5; i++)
      cyc(1, 0, 0, MODE_SHR, 1, 1, 8'hFF, 8'hAD, 4'd1, 0, "gate_off");
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parametrised universal shift register: the next generation of the team's fixed 4-bit right-shifting serial-in/serial-out register. It adds configurable width, per-cycle mode select (hold, shift right, shift left, parallel load), a synchronous clear and a shift counter. The counter flags each completed frame of WIDTH shifts. It serves as the serialiser/deserialiser stage between byte-wide datapaths and single-bit links.

## Interface
- `WIDTH`, default 8: register width in bits; legal range ≥ 2.
- `CNT_W`, default `$clog2(WIDTH+1)`: shift-counter width. Derived; never overridden.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `en`  in  1: clock enable. When low, mode is ignored and all state holds.
- `clr`  in  1: synchronous clear. Zeroes the register and the counter.
- `mode`  in  2: operation select. 00 HOLD, 01 SHR, 10 SHL, 11 LOAD.
- `serial_in_msb`  in  1: bit entering the MSB on SHR.
- `serial_in_lsb`  in  1: bit entering the LSB on SHL.
- `par_in`  in  WIDTH: parallel load data.
- `q`  out  WIDTH: register contents.
- `serial_out_r`  out  1: equals `q[0]`. This is the bit leaving on SHR.
- `serial_out_l`  out  1: equals `q[WIDTH-1]`. This is the bit leaving on SHL.
- `shift_cnt`  out  CNT_W: number of shifts since the last load, clear, reset or frame wrap.
- `frame_done`  out  1: single-cycle registered pulse marking completion of WIDTH shifts.

## Operation
- Priority order is `rst` > `clr` > `en`=0 > mode.
- `clr`=1 (with `en` either value): `q`←0, `shift_cnt`←0, `frame_done`←0.
- HOLD: `q` and `shift_cnt` unchanged.
- SHR: `q` ← {`serial_in_msb`, `q[WIDTH-1:1]`}. With WIDTH=4 this matches the legacy block bit-for-bit.
- SHL: `q` ← {`q[WIDTH-2:0]`, `serial_in_lsb`}.
- LOAD: `q` ← `par_in`, `shift_cnt` ← 0.
- Shift counting:
  - Each SHR or SHL cycle with `en`=1 increments `shift_cnt`.
  - SHR and SHL count together, so a direction change does not reset the count.
  - When `shift_cnt`==WIDTH-1 and a shift occurs, `shift_cnt` wraps to 0 and `frame_done` is 1 on the next cycle.
- `frame_done` is 0 in every other cycle, including HOLD, LOAD, clear and `en`=0 cycles.
- The serial outputs are combinational taps of `q`. They carry no extra register stage.

## Timing
- Reset values: `q`=0, `shift_cnt`=0, `frame_done`=0. Therefore `serial_out_r`=`serial_out_l`=0.
- `rst` takes effect immediately on assertion, independent of `clk`. The first operation executes on the first rising edge after deassertion.
- Reset asserted mid-frame discards the partial count. No `frame_done` is produced for the aborted frame.
- Latency:
  - `q` reflects an operation one cycle after the edge that samples it.
  - `frame_done` rises in the same cycle that `q` holds the WIDTH-th shifted value.
- Back-to-back frames: continuous shifting gives a `frame_done` every WIDTH cycles with no gap.
- LOAD in the cycle that would have completed a frame: the load wins, `shift_cnt`=0 and no `frame_done`.
- `clr` together with `en`=0: the clear still occurs.
- The mode input is sampled only on edges where `en`=1. Its value is don't-care otherwise.

## Structure
- Package `usr_pkg`:
  - enum `usr_mode_e` with `MODE_HOLD`=2'b00, `MODE_SHR`=2'b01, `MODE_SHL`=2'b10, `MODE_LOAD`=2'b11.
  - function computing `CNT_W` from `WIDTH`.
- Sub-module `usr_frame_counter` (params `WIDTH`, `CNT_W`):
  - Inputs: `clk`, `rst`, `inc`, `zero`.
  - Outputs: `cnt`, `done`.
  - Owns the wrap and pulse logic so the top level is datapath only.
- Top level contains the `q` register, the mode decode and the serial taps.

## Test plan
- Reset: drive `rst`=1 mid-stream with WIDTH=4 and `q`=4'b1011 → `q`=0, `shift_cnt`=0, `frame_done`=0 immediately, with no clock edge needed.
- Legacy equivalence: WIDTH=4, SHR with `serial_in_msb` sequence 1,0,1,1 → `q` steps 1000, 0100, 1010, 1101. `serial_out_r` tracks `q[0]` each cycle. `frame_done`=1 in the cycle `q`=1101.
- Left shift and wrap: WIDTH=8, LOAD 8'hA5, then 8 SHL with `serial_in_lsb`=0 → `serial_out_l` emits 1,0,1,0,0,1,0,1, then `q`=8'h00. `frame_done` pulses once and `shift_cnt` returns to 0.
- Mixed direction: WIDTH=4, LOAD 4'b0110, then SHR (in 0), SHL (in 1), HOLD, SHR (in 1) → `q`=0011, 0111, 0111, 1011. `shift_cnt`=3 with no `frame_done`. One more shift produces the pulse.
- Priority: at `shift_cnt`=WIDTH-1, apply LOAD 8'h3C → `q`=8'h3C, `shift_cnt`=0, no pulse. Next apply `clr`=1 with `en`=0 and `mode`=SHR → `q`=0.
- Enable gating: `en`=0 for 5 cycles with `mode`=SHR and `serial_in_msb`=1 → `q`, `shift_cnt` and the serial outputs are unchanged and `frame_done` stays 0.
